// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM access arbiter: owner codes, FSM encoding, default widths.
package ram_arb_pkg;

   localparam int DEF_DIR_W  = 32;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INIT = 2'd1,
      OWN_RTC  = 2'd2,
      OWN_VGA  = 2'd3
   } owner_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

endpackage

// File: rtl/ram_arb_if.sv
// Requester, RAM and read-return signals of the arbiter; slave = arbiter side, master = environment.
interface ram_arb_if #(
   parameter int DIR_W  = ram_arb_pkg::DEF_DIR_W,
   parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
   logic              init_req, rtc_req, vga_req;
   logic              init_we,  rtc_we,  vga_we;
   logic [DIR_W-1:0]  init_dir, rtc_dir, vga_dir;
   logic [DATA_W-1:0] init_din, rtc_din, vga_din;
   logic              init_gnt, rtc_gnt, vga_gnt;
   logic [DIR_W-1:0]  dir_ram;
   logic              w_ram_enable, r_ram_enable;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [1:0]        rd_owner;
   logic              onehot_err;

   modport slave (
      input  init_req, rtc_req, vga_req,
      input  init_we, rtc_we, vga_we,
      input  init_dir, rtc_dir, vga_dir,
      input  init_din, rtc_din, vga_din,
      input  ram_dout,
      output init_gnt, rtc_gnt, vga_gnt,
      output dir_ram, w_ram_enable, r_ram_enable, ram_din,
      output rd_data, rd_valid, rd_owner, onehot_err
   );

   modport master (
      output init_req, rtc_req, vga_req,
      output init_we, rtc_we, vga_we,
      output init_dir, rtc_dir, vga_dir,
      output init_din, rtc_din, vga_din,
      output ram_dout,
      input  init_gnt, rtc_gnt, vga_gnt,
      input  dir_ram, w_ram_enable, r_ram_enable, ram_din,
      input  rd_data, rd_valid, rd_owner, onehot_err
   );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Round-robin chooser between the rtc and vga requesters (combinational).
module ram_arb_rr_pick
   import ram_arb_pkg::*;
(
   input  logic   favour_vga,
   input  logic   rtc_req,
   input  logic   vga_req,
   output owner_t pick
);

   always_comb begin
      pick = OWN_NONE;
      if (rtc_req && vga_req) begin
         pick = favour_vga ? OWN_VGA : OWN_RTC;
      end else if (rtc_req) begin
         pick = OWN_RTC;
      end else if (vga_req) begin
         pick = OWN_VGA;
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port RAM arbiter for init/rtc/vga requesters with burst limit and 1-cycle read return.
// Optional one-hot address check enabled by defining RAM_ARB_ONEHOT_CHK_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner, RAM outputs quiet, arbitration of pending reqs
//   ST_OWN  | owner_q holds the bus; strobes follow the owner's req/we
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DIR_W     = DEF_DIR_W
) (
   input logic      clk,
   input logic      reset,
   ram_arb_if.slave bus
);

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            rr_pick;
   logic [7:0]        burst_q, burst_d;
   logic              rr_vga_q, rr_vga_d;
   logic              own_req, own_we, others_req;
   logic [DIR_W-1:0]  own_dir;
   logic [DATA_W-1:0] own_din;
   logic              access, dir_ok, w_en, r_en, err_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   owner_t            rd_owner_q;

   ram_arb_rr_pick u_rr_pick (
      .favour_vga (rr_vga_q),
      .rtc_req    (bus.rtc_req),
      .vga_req    (bus.vga_req),
      .pick       (rr_pick)
   );

   always_comb begin
      own_req    = 1'b0;
      own_we     = 1'b0;
      own_dir    = '0;
      own_din    = '0;
      others_req = 1'b0;
      case (owner_q)
         OWN_INIT: begin
            own_req = bus.init_req; own_we = bus.init_we;
            own_dir = bus.init_dir; own_din = bus.init_din;
            others_req = bus.rtc_req | bus.vga_req;
         end
         OWN_RTC: begin
            own_req = bus.rtc_req; own_we = bus.rtc_we;
            own_dir = bus.rtc_dir; own_din = bus.rtc_din;
            others_req = bus.init_req | bus.vga_req;
         end
         OWN_VGA: begin
            own_req = bus.vga_req; own_we = bus.vga_we;
            own_dir = bus.vga_dir; own_din = bus.vga_din;
            others_req = bus.init_req | bus.rtc_req;
         end
         default: ;
      endcase
   end

   assign access = (state_q == ST_OWN) && own_req;

`ifdef RAM_ARB_ONEHOT_CHK_EN
   assign dir_ok = (own_dir != '0) && ((own_dir & (own_dir - DIR_W'(1))) == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (access && !dir_ok) begin
         err_q <= 1'b1;
      end
   end
`else
   assign dir_ok = 1'b1;
   assign err_q  = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_NONE;
         burst_q  <= '0;
         rr_vga_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         burst_q  <= burst_d;
         rr_vga_q <= rr_vga_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      burst_d  = burst_q;
      rr_vga_d = rr_vga_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.init_req) begin
               state_d = ST_OWN;
               owner_d = OWN_INIT;
               burst_d = '0;
            end else if (bus.rtc_req || bus.vga_req) begin
               state_d  = ST_OWN;
               owner_d  = rr_pick;
               burst_d  = '0;
               rr_vga_d = (rr_pick == OWN_RTC);
            end
         end
         ST_OWN: begin
            if (!own_req) begin
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
               burst_d = '0;
            end else if ((owner_q != OWN_INIT) && others_req && (burst_q == BURST_LAST)) begin
               // this access is the last one allowed while someone else waits
               state_d = ST_IDLE;
               owner_d = OWN_NONE;
               burst_d = '0;
            end else if (burst_q != 8'hFF) begin
               burst_d = burst_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_comb begin
      bus.init_gnt     = (state_q == ST_OWN) && (owner_q == OWN_INIT);
      bus.rtc_gnt      = (state_q == ST_OWN) && (owner_q == OWN_RTC);
      bus.vga_gnt      = (state_q == ST_OWN) && (owner_q == OWN_VGA);
      w_en             = access && own_we && dir_ok;
      r_en             = access && !own_we && dir_ok;
      bus.w_ram_enable = w_en;
      bus.r_ram_enable = r_en;
      bus.dir_ram      = access ? own_dir : '0;
      bus.ram_din      = access ? own_din : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_owner_q <= OWN_NONE;
      end else begin
         rd_valid_q <= r_en;
         if (r_en) begin
            rd_data_q  <= bus.ram_dout;
            rd_owner_q <= owner_q;
         end
      end
   end

   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_owner   = rd_owner_q;
   assign bus.onehot_err = err_q;

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8: maximum consecutive access cycles for rtc/vga owner when another requester waits (range 1..255).
REQ-002 Parameter DATA_W, default 8: RAM data width.
REQ-003 Parameter DIR_W, default 32: one-hot RAM address width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 init_req / rtc_req / vga_req  in  1 each  access request from RAM-init FSM, RTC control FSM, VGA reader.
REQ-007 init_we / rtc_we / vga_we  in  1 each  1=write, 0=read for that requester's current cycle.
REQ-008 init_dir / rtc_dir / vga_dir  in  DIR_W each  one-hot RAM address.
REQ-009 init_din / rtc_din / vga_din  in  DATA_W each  write data.
REQ-010 init_gnt / rtc_gnt / vga_gnt  out  1 each  registered grant, at most one high.
REQ-011 dir_ram  out  DIR_W  address to RAM.
REQ-012 w_ram_enable / r_ram_enable  out  1 each  RAM write/read strobes, never both high.
REQ-013 ram_din  out  DATA_W  write data to RAM.
REQ-014 ram_dout  in  DATA_W  RAM read data, valid same cycle as r_ram_enable.
REQ-015 rd_data  out  DATA_W  registered read data.
REQ-016 rd_valid  out  1  rd_data valid pulse.
REQ-017 rd_owner  out  2  requester code belonging to rd_data.
REQ-018 onehot_err  out  1  sticky address-error flag (tied 0 when feature compiled out).

Function
REQ-019 FSM states IDLE, OWN; owner register holds requester code NONE=0, INIT=1, RTC=2, VGA=3.
REQ-020 IDLE: if any req high, pick winner, enter OWN next edge with winner's gnt high; else stay IDLE.
REQ-021 Priority: init highest; between rtc and vga round-robin, pointer favours the one not most recently granted; pointer resets to favour rtc.
REQ-022 OWN: while owner's req high, dir_ram/ram_din follow owner inputs combinationally; w_ram_enable=req&we, r_ram_enable=req&~we.
REQ-023 OWN -> IDLE when owner's req low (gnt drops same edge), or when burst counter reaches MAX_BURST with any other req pending.
REQ-024 Burst counter clears on entering OWN, increments each strobe cycle; owner INIT is exempt from burst limit.
REQ-025 IDLE and any cycle with gnt low: dir_ram, ram_din, both strobes = 0; minimum one idle cycle between owners.
REQ-026 Read return: rd_data<=ram_dout, rd_owner<=owner, rd_valid<=1 on edge after r_ram_enable; latency 1 cycle; rd_valid 0 otherwise.
REQ-027 Requests from non-owners are ignored (held, not lost); requester keeps req high until granted.
REQ-028 Simultaneous owner release and new requests: transition to IDLE first, arbitration in IDLE next cycle.

Reset
REQ-029 reset low: state IDLE, owner NONE, all gnt 0, strobes 0, dir_ram 0, ram_din 0, rd_valid 0, rd_data 0, rd_owner 0, burst counter 0, onehot_err 0, immediately (asynchronous), including mid-burst.

Configuration
REQ-030 Macro RAM_ARB_ONEHOT_CHK_EN defined: strobe cycle with owner dir not exactly one-hot suppresses both strobes and sets onehot_err until reset.
REQ-031 Macro undefined: no check, dir passed unchanged, onehot_err tied 0.

Structure
REQ-032 Package ram_arb_pkg holds owner codes, FSM state encoding, default DIR_W/DATA_W.
REQ-033 Sub-module ram_arb_rr_pick: combinational rtc/vga round-robin chooser given pointer and requests.

Verification
REQ-034 Init only: init_req high 32 cycles, dir one-hot walking, we=1 -> init_gnt at cycle 1, 32 write strobes, dir_ram matches, no burst break.
REQ-035 rtc and vga raise req same cycle after reset -> rtc_gnt first; after rtc releases, 1 idle cycle, vga_gnt.
REQ-036 MAX_BURST=4, vga reads continuously, rtc_req pending -> vga loses gnt after 4 strobes, rtc granted after 1 idle cycle.
REQ-037 rtc read dir=0x00000004, ram_dout=0x23 -> rd_valid 1 cycle later, rd_data=0x23, rd_owner=2.
REQ-038 reset low mid vga burst -> all gnt/strobes 0 without clock edge; after release, IDLE and rtc favoured.
REQ-039 With RAM_ARB_ONEHOT_CHK_EN, rtc write dir=0x00000006 -> no w_ram_enable, onehot_err=1 sticky.
